nway_wb_cache: RTL

Parametrised N-way set-associative write-back, write-allocate data cache between the memory stage (ALUResultM/WriteDataM) and the data memory. It generalises the 2-way miss cache to configurable set and way counts, with true LRU replacement, dirty-line write-back and a blocking miss FSM. The FSM drives a request/valid handshake to data memory and stalls the pipeline until the access completes. Lines are one word; byte offset is ignored.

---
 rtl/nway_wb_cache.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/nway_wb_cache.sv
// rtl/nway_wb_cache.sv - N-way set-associative write-back/write-allocate cache, true LRU, blocking miss FSM; optional CACHE_STATS_EN hit/miss counters
module nway_wb_cache #(
  parameter int NUM_SET = 4,
  parameter int NUM_WAY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] Data,
  output logic        Hit,
  output logic        Stall,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  input  logic [31:0] MemReadData,
  input  logic        MemValid
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] HitCount,
  output logic [31:0] MissCount
`endif
);

  localparam int SET_W = $clog2(NUM_SET);
  localparam int TAG_W = 30 - SET_W;
  localparam int WAY_W = $clog2(NUM_WAY);

  typedef logic [NUM_WAY-1:0][WAY_W-1:0] ages_t;

  // Ages start as a permutation (way w has age w) so the LRU order is always total.
  function automatic ages_t init_ages();
    ages_t r;
    for (int w = 0; w < NUM_WAY; w++) r[w] = WAY_W'(w);
    return r;
  endfunction

  localparam ages_t AGE_INIT = init_ages();

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2
  } state_t;

  state_t                            state_q;
  logic [NUM_SET-1:0][NUM_WAY-1:0]   valid_q;
  logic [NUM_SET-1:0][NUM_WAY-1:0]   dirty_q;
  ages_t [NUM_SET-1:0]               age_q;
  logic [TAG_W-1:0]                  tag_q  [NUM_SET][NUM_WAY];
  logic [31:0]                       data_q [NUM_SET][NUM_WAY];

  logic                              mem_read_q;
  logic                              mem_write_q;
  logic [31:0]                       mem_addr_q;
  logic [31:0]                       mem_wdata_q;
  logic [WAY_W-1:0]                  victim_q;
  logic [31:2]                       req_addr_q;

  logic                              req;
  logic [SET_W-1:0]                  req_set;
  logic [TAG_W-1:0]                  req_tag;
  logic [SET_W-1:0]                  fill_set;
  logic [TAG_W-1:0]                  fill_tag;
  logic                              hit_any;
  logic [WAY_W-1:0]                  hit_way;
  logic [WAY_W-1:0]                  victim_way;
  logic                              victim_found;
  ages_t                             age_nxt;
  logic                              unused_byte_offset;

  assign req      = MemReadM | MemWriteM;
  assign req_set  = ALUResultM[SET_W+1:2];
  assign req_tag  = ALUResultM[31:SET_W+2];
  assign fill_set = req_addr_q[SET_W+1:2];
  assign fill_tag = req_addr_q[31:SET_W+2];

  // Lines are one word, so the byte offset never takes part in the lookup.
  assign unused_byte_offset = ^ALUResultM[1:0];

  // Tag compare across the ways of the addressed set
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAY; w++) begin
      if (!hit_any && valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest-index invalid way, otherwise the oldest way of the set
  always_comb begin
    victim_found = 1'b0;
    victim_way   = '0;
    for (int w = 0; w < NUM_WAY; w++) begin
      if (!victim_found && !valid_q[req_set][w]) begin
        victim_found = 1'b1;
        victim_way   = WAY_W'(w);
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < NUM_WAY; w++) begin
        if (age_q[req_set][w] == WAY_W'(NUM_WAY - 1)) victim_way = WAY_W'(w);
      end
    end
  end

  // True-LRU ages after touching the hit way: it becomes youngest, younger ways shift up
  always_comb begin
    age_nxt = age_q[req_set];
    for (int w = 0; w < NUM_WAY; w++) begin
      if (WAY_W'(w) == hit_way) begin
        age_nxt[w] = '0;
      end else if (age_q[req_set][w] < age_q[req_set][hit_way]) begin
        age_nxt[w] = age_q[req_set][w] + 1'b1;
      end
    end
  end

  assign Hit          = hit_any;
  assign Data         = (hit_any && MemReadM) ? data_q[req_set][hit_way] : 32'h0;
  assign Stall        = req & (~hit_any | (state_q != S_IDLE));
  assign MemRead      = mem_read_q;
  assign MemWrite     = mem_write_q;
  assign MemAddress   = mem_addr_q;
  assign MemWriteData = mem_wdata_q;

  // Miss FSM with line state (valid/dirty/age) and registered memory request outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      age_q       <= {NUM_SET{AGE_INIT}};
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      victim_q    <= '0;
      req_addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (hit_any) begin
              age_q[req_set] <= age_nxt;
              if (MemWriteM) dirty_q[req_set][hit_way] <= 1'b1;
            end else begin
              victim_q   <= victim_way;
              req_addr_q <= ALUResultM[31:2];
              if (valid_q[req_set][victim_way] && dirty_q[req_set][victim_way]) begin
                state_q     <= S_WRITEBACK;
                mem_write_q <= 1'b1;
                mem_addr_q  <= {tag_q[req_set][victim_way], req_set, 2'b00};
                mem_wdata_q <= data_q[req_set][victim_way];
              end else begin
                state_q    <= S_FILL;
                mem_read_q <= 1'b1;
                mem_addr_q <= {req_tag, req_set, 2'b00};
              end
            end
          end
        end
        S_WRITEBACK: begin
          if (MemValid) begin
            dirty_q[fill_set][victim_q] <= 1'b0;
            mem_write_q                 <= 1'b0;
            mem_read_q                  <= 1'b1;
            mem_addr_q                  <= {fill_tag, fill_set, 2'b00};
            state_q                     <= S_FILL;
          end
        end
        S_FILL: begin
          if (MemValid) begin
            valid_q[fill_set][victim_q] <= 1'b1;
            dirty_q[fill_set][victim_q] <= 1'b0;
            mem_read_q                  <= 1'b0;
            state_q                     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag/data storage: store hits write the hit way, completed fills write the victim way
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req && hit_any && MemWriteM) begin
      data_q[req_set][hit_way] <= WriteDataM;
    end
    if (state_q == S_FILL && MemValid) begin
      tag_q[fill_set][victim_q]  <= fill_tag;
      data_q[fill_set][victim_q] <= MemReadData;
    end
  end

`ifdef CACHE_STATS_EN
  logic        retry_q;
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  assign HitCount  = hit_count_q;
  assign MissCount = miss_count_q;

  // Demand hit/miss counters; the hit that completes a just-filled miss is not a new hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_q      <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (state_q == S_FILL && MemValid) begin
        retry_q <= 1'b1;
      end else if (state_q == S_IDLE) begin
        retry_q <= 1'b0;
      end
      if (state_q == S_IDLE && req && hit_any && !retry_q) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (state_q == S_IDLE && req && !hit_any) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end
`endif

endmodule
